branch_resolve_e: RTL and testbench

- Execute-stage redirect unit; the producer of the PCSrcE/PCTargetE pair that the Fetch stage consumes.
- Holds the ID/EX pipeline register for control-flow fields.
- Evaluates branch conditions against the ALU flags in EX and computes the 15-bit redirect target.
- Squashes the wrong-path instructions in IF/ID and ID/EX.

---
 rtl/branch_resolve_e.sv | 117 +++++++++++
 tb/tb_branch_resolve_e.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_e.sv
// Execute-stage branch/jump resolution: ID/EX control register, condition check, redirect and squash.
// Optional resolved/taken branch counters are built when BRANCH_STATS_EN is defined.
module branch_resolve_e #(
  parameter int PC_W   = 15,
  parameter int COND_W = 3,
  parameter int STAT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              StallE,
  input  logic              FlushExtE,
  input  logic              ValidD,
  input  logic              BranchD,
  input  logic              JumpD,
  input  logic              JumpRegD,
  input  logic [COND_W-1:0] CondD,
  input  logic [PC_W-1:0]   PCD,
  input  logic [PC_W-1:0]   ImmExtD,
  input  logic [PC_W-1:0]   SrcAE,
  input  logic [3:0]        FlagsE,
  output logic              PCSrcE,
  output logic [PC_W-1:0]   PCTargetE,
  output logic              FlushD,
  output logic              FlushE,
`ifdef BRANCH_STATS_EN
  output logic [STAT_W-1:0] BrCountE,
  output logic [STAT_W-1:0] TakenCountE,
`endif
  output logic [PC_W-1:0]   PCE
);

  typedef struct packed {
    logic              valid;
    logic              branch;
    logic              jump;
    logic              jumpreg;
    logic [COND_W-1:0] cond;
    logic [PC_W-1:0]   pc;
    logic [PC_W-1:0]   imm;
  } idex_t;

  idex_t r_idex;
  idex_t w_idex_d;
  logic  w_cond;
  logic  w_take;

  logic w_n, w_z, w_c, w_v;
  assign {w_n, w_z, w_c, w_v} = FlagsE;

  assign w_idex_d = '{valid:   ValidD,
                      branch:  BranchD,
                      jump:    JumpD,
                      jumpreg: JumpRegD,
                      cond:    CondD,
                      pc:      PCD,
                      imm:     ImmExtD};

  // A redirect squashes the younger instruction even while the hazard unit stalls.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_idex <= '0;
    end else if (FlushExtE | w_take) begin
      r_idex <= '0;
    end else if (!StallE) begin
      r_idex <= w_idex_d;
    end
  end

  // NOTE: the default before the case keeps this purely combinational (no latch).
  always_comb begin
    w_cond = 1'b0;
    case (r_idex.cond)
      3'b000:  w_cond = w_z;
      3'b001:  w_cond = !w_z;
      3'b010:  w_cond = w_n ^ w_v;
      3'b011:  w_cond = !(w_n ^ w_v);
      3'b100:  w_cond = !w_c;
      3'b101:  w_cond = w_c;
      3'b110:  w_cond = 1'b1;
      default: w_cond = 1'b0;
    endcase
  end

  assign w_take    = r_idex.valid & ((r_idex.branch & w_cond) | r_idex.jump | r_idex.jumpreg);
  assign PCSrcE    = w_take;
  // Target wraps modulo 2^PC_W; carry out is intentionally dropped.
  assign PCTargetE = (r_idex.jumpreg ? SrcAE : r_idex.pc) + r_idex.imm;
  assign FlushD    = w_take;
  assign FlushE    = w_take | FlushExtE;
  assign PCE       = r_idex.pc;

`ifdef BRANCH_STATS_EN
  logic [STAT_W-1:0] r_br_count;
  logic [STAT_W-1:0] r_taken_count;
  logic              w_resolve;

  // A stalled branch is only counted on the edge it finally advances.
  assign w_resolve = r_idex.valid & r_idex.branch & !StallE;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_br_count    <= '0;
      r_taken_count <= '0;
    end else if (w_resolve) begin
      if (r_br_count != '1)
        r_br_count <= r_br_count + 1'b1;
      if (w_cond && (r_taken_count != '1))
        r_taken_count <= r_taken_count + 1'b1;
    end
  end

  assign BrCountE    = r_br_count;
  assign TakenCountE = r_taken_count;
`endif

endmodule

// File: tb/tb_branch_resolve_e.sv
// Directed bench for branch_resolve_e: vector table for single-instruction resolution plus
// hand-written stall/flush/reset sequences; counter checks when BRANCH_STATS_EN is defined.
module tb_branch_resolve_e;

  logic        clk;
  logic        reset;
  logic        StallE, FlushExtE;
  logic        ValidD, BranchD, JumpD, JumpRegD;
  logic [2:0]  CondD;
  logic [14:0] PCD, ImmExtD, SrcAE;
  logic [3:0]  FlagsE;
  logic        PCSrcE, FlushD, FlushE;
  logic [14:0] PCTargetE, PCE;
`ifdef BRANCH_STATS_EN
  logic [15:0] BrCountE, TakenCountE;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  branch_resolve_e dut (
    .clk       (clk),
    .reset     (reset),
    .StallE    (StallE),
    .FlushExtE (FlushExtE),
    .ValidD    (ValidD),
    .BranchD   (BranchD),
    .JumpD     (JumpD),
    .JumpRegD  (JumpRegD),
    .CondD     (CondD),
    .PCD       (PCD),
    .ImmExtD   (ImmExtD),
    .SrcAE     (SrcAE),
    .FlagsE    (FlagsE),
    .PCSrcE    (PCSrcE),
    .PCTargetE (PCTargetE),
    .FlushD    (FlushD),
    .FlushE    (FlushE),
`ifdef BRANCH_STATS_EN
    .BrCountE    (BrCountE),
    .TakenCountE (TakenCountE),
`endif
    .PCE       (PCE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        valid, branch, jump, jumpreg;
    logic [2:0]  cond;
    logic [14:0] pc, imm, srca;
    logic [3:0]  flags;
    logic        exp_take;
    logic [14:0] exp_tgt;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic v, input logic b, input logic j, input logic jr,
                              input logic [2:0] c, input logic [14:0] pc, input logic [14:0] imm,
                              input logic [14:0] srca, input logic [3:0] fl,
                              input logic take, input logic [14:0] tgt);
    vec_t r;
    r.valid = v; r.branch = b; r.jump = j; r.jumpreg = jr; r.cond = c;
    r.pc = pc; r.imm = imm; r.srca = srca; r.flags = fl;
    r.exp_take = take; r.exp_tgt = tgt;
    return r;
  endfunction

  task automatic drive_d(input logic v, input logic b, input logic j, input logic jr,
                         input logic [2:0] c, input logic [14:0] pc, input logic [14:0] imm);
    ValidD = v; BranchD = b; JumpD = j; JumpRegD = jr; CondD = c; PCD = pc; ImmExtD = imm;
  endtask

  task automatic drive_idle();
    drive_d(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 15'h0, 15'h0);
  endtask

  // Flags are {N,Z,C,V}.
  initial begin
    vecs[0]  = mk(1,1,0,0, 3'b000, 15'h0010, 15'h0008, 15'h0000, 4'b0100, 1, 15'h0018); // BEQ taken
    vecs[1]  = mk(1,1,0,0, 3'b001, 15'h0010, 15'h0008, 15'h0000, 4'b0100, 0, 15'h0018); // BNE, Z=1
    vecs[2]  = mk(1,1,0,0, 3'b001, 15'h0010, 15'h0008, 15'h0000, 4'b0000, 1, 15'h0018); // BNE, Z=0
    vecs[3]  = mk(1,1,0,0, 3'b010, 15'h0100, 15'h7FF0, 15'h0000, 4'b1000, 1, 15'h00F0); // LT, back
    vecs[4]  = mk(1,1,0,0, 3'b011, 15'h0200, 15'h0020, 15'h0000, 4'b1001, 1, 15'h0220); // GE N=V=1
    vecs[5]  = mk(1,1,0,0, 3'b100, 15'h0300, 15'h0004, 15'h0000, 4'b0010, 0, 15'h0304); // LTU, C=1
    vecs[6]  = mk(1,1,0,0, 3'b101, 15'h0300, 15'h0004, 15'h0000, 4'b0010, 1, 15'h0304); // GEU, C=1
    vecs[7]  = mk(1,1,0,0, 3'b110, 15'h0400, 15'h0100, 15'h0000, 4'b0000, 1, 15'h0500); // ALWAYS
    vecs[8]  = mk(1,1,0,0, 3'b111, 15'h0400, 15'h0100, 15'h0000, 4'b1111, 0, 15'h0500); // NEVER
    vecs[9]  = mk(1,0,1,0, 3'b000, 15'h7FFE, 15'h0004, 15'h0000, 4'b0000, 1, 15'h0002); // JAL wrap
    vecs[10] = mk(1,0,0,1, 3'b000, 15'h0040, 15'h7FFF, 15'h1234, 4'b0000, 1, 15'h1233); // JALR
    vecs[11] = mk(0,0,1,0, 3'b000, 15'h0044, 15'h0010, 15'h0000, 4'b0000, 0, 15'h0054); // invalid
    vecs[12] = mk(1,1,1,0, 3'b111, 15'h0080, 15'h0020, 15'h0500, 4'b0000, 1, 15'h00A0); // B+J
    vecs[13] = mk(1,1,0,1, 3'b111, 15'h0080, 15'h0020, 15'h0500, 4'b0000, 1, 15'h0520); // B+JR
  end

  initial begin
    // Reset with random inputs.
    reset = 1'b0;
    StallE = 1'($urandom); FlushExtE = 1'($urandom);
    drive_d(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 3'($urandom),
            15'($urandom), 15'($urandom));
    SrcAE = 15'($urandom); FlagsE = 4'($urandom);
    #12;
    check("rst_pcsrc", PCSrcE, 0);
    check("rst_tgt", PCTargetE, 0);
    check("rst_flushd", FlushD, 0);
    check("rst_flushe", FlushE, FlushExtE);
    check("rst_pce", PCE, 0);

    @(negedge clk);
    StallE = 0; FlushExtE = 0; SrcAE = 0; FlagsE = 0;
    drive_idle();
    reset = 1'b1;
    @(negedge clk);
    check("post_rst_pcsrc", PCSrcE, 0);
    check("post_rst_tgt", PCTargetE, 0);
    check("post_rst_pce", PCE, 0);

    // Table: idle cycle, load vector, apply EX flags/operand, check.
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      drive_idle(); FlagsE = 0; SrcAE = 0;
      @(negedge clk);
      drive_d(vecs[i].valid, vecs[i].branch, vecs[i].jump, vecs[i].jumpreg,
              vecs[i].cond, vecs[i].pc, vecs[i].imm);
      @(posedge clk);
      #1;
      drive_idle();
      FlagsE = vecs[i].flags; SrcAE = vecs[i].srca;
      #1;
      check($sformatf("v%0d_pcsrc", i), PCSrcE, vecs[i].exp_take);
      check($sformatf("v%0d_tgt", i), PCTargetE, vecs[i].exp_tgt);
      check($sformatf("v%0d_flushd", i), FlushD, vecs[i].exp_take);
      check($sformatf("v%0d_flushe", i), FlushE, vecs[i].exp_take);
      check($sformatf("v%0d_pce", i), PCE, vecs[i].pc);
    end

    // Taken BEQ: the younger instruction behind it becomes a bubble.
    @(negedge clk); drive_idle(); FlagsE = 0;
    @(negedge clk); drive_d(1,1,0,0, 3'b000, 15'h0010, 15'h0008);
    @(negedge clk); FlagsE = 4'b0100; drive_d(1,0,0,0, 3'b000, 15'h0014, 15'h0000);
    #1;
    check("beq_taken", PCSrcE, 1);
    @(negedge clk); FlagsE = 4'b0100; drive_idle();
    check("beq_after_pcsrc", PCSrcE, 0);
    check("beq_after_pce", PCE, 0);

    // Not-taken BNE: next instruction enters E normally.
    @(negedge clk); drive_d(1,1,0,0, 3'b001, 15'h0010, 15'h0008);
    @(negedge clk); FlagsE = 4'b0100; drive_d(1,0,0,0, 3'b000, 15'h0014, 15'h0000);
    #1;
    check("bne_nt_pcsrc", PCSrcE, 0);
    check("bne_nt_flushd", FlushD, 0);
    @(negedge clk); drive_idle();
    check("bne_next_pce", PCE, 15'h0014);

    // Stall holds a non-branch for three edges.
    @(negedge clk); drive_d(1,0,0,0, 3'b000, 15'h0050, 15'h0000);
    @(negedge clk); StallE = 1; drive_d(1,0,0,0, 3'b000, 15'h0054, 15'h0000);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("stall_hold%0d", k), PCE, 15'h0050);
    end
    StallE = 0;

    // Taken jump under stall still loads a bubble.
    @(negedge clk); drive_d(1,0,1,0, 3'b000, 15'h0060, 15'h0010);
    @(negedge clk); StallE = 1; drive_d(1,0,0,0, 3'b000, 15'h0064, 15'h0000);
    #1;
    check("stall_jmp_pcsrc", PCSrcE, 1);
    check("stall_jmp_tgt", PCTargetE, 15'h0070);
    @(negedge clk);
    check("stall_jmp_bubble_pcsrc", PCSrcE, 0);
    check("stall_jmp_bubble_pce", PCE, 0);
    StallE = 0;

    // External flush alone.
    @(negedge clk); drive_d(1,0,0,0, 3'b000, 15'h0070, 15'h0000);
    @(negedge clk); drive_idle(); FlushExtE = 1; StallE = 1;
    #1;
    check("fext_flushe", FlushE, 1);
    check("fext_flushd", FlushD, 0);
    @(negedge clk); FlushExtE = 0; StallE = 0;
    check("fext_bubble_pce", PCE, 0);

    // Async reset in the middle of a taken jump.
    @(negedge clk); drive_d(1,0,1,0, 3'b000, 15'h0120, 15'h0010);
    @(negedge clk); drive_idle();
    #1;
    check("arst_pre_pcsrc", PCSrcE, 1);
    reset = 1'b0;
    #1;
    check("arst_pcsrc", PCSrcE, 0);
    check("arst_pce", PCE, 0);
    @(negedge clk); reset = 1'b1;

`ifdef BRANCH_STATS_EN
    @(negedge clk); reset = 1'b0;
    @(negedge clk); reset = 1'b1;
    // Five branches: BEQ Z=1 (T), BEQ Z=0 (N), BNE Z=0 (T), GEU C=0 (N), ALWAYS (T).
    for (int b = 0; b < 5; b++) begin
      logic [2:0] c;
      logic [3:0] f;
      c = (b == 0 || b == 1) ? 3'b000 : (b == 2) ? 3'b001 : (b == 3) ? 3'b101 : 3'b110;
      f = (b == 0) ? 4'b0100 : 4'b0000;
      @(negedge clk); drive_d(1,1,0,0, c, 15'h0200, 15'h0010); FlagsE = 0;
      @(negedge clk); drive_idle(); FlagsE = f;
    end
    @(negedge clk); FlagsE = 0;
    check("stats_br", BrCountE, 5);
    check("stats_taken", TakenCountE, 3);
    force dut.r_br_count = 16'hFFFF;
    force dut.r_taken_count = 16'hFFFF;
    #1;
    release dut.r_br_count;
    release dut.r_taken_count;
    @(negedge clk); drive_d(1,1,0,0, 3'b110, 15'h0200, 15'h0010);
    @(negedge clk); drive_idle();
    @(negedge clk);
    check("stats_sat_br", BrCountE, 16'hFFFF);
    check("stats_sat_taken", TakenCountE, 16'hFFFF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
